// File: rtl/tcam_lookup_sched_if.sv
// tcam_lookup_sched_if: packet, config, TCAM and result buses of the lookup scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface tcam_lookup_sched_if #(
    parameter int ID_WIDTH     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ADDR_SIZE    = 4,
    parameter int BITS         = 8
);
    logic                    pkt_valid, pkt_ready;
    logic [ID_WIDTH-1:0]     pkt_id;
    logic                    cfg_valid, cfg_ready, cfg_flush;
    logic [ADDR_SIZE-1:0]    cfg_addr;
    logic [BITS-1:0]         cfg_data, cfg_mask;
    logic                    mem_cs, mem_wr, mem_flush, mem_cmp;
    logic [ADDR_SIZE-1:0]    mem_addr;
    logic [BITS-1:0]         mem_data, mem_mask;
    logic [ID_WIDTH-1:0]     mem_pkt_id, mem_dst_id;
    logic [WEIGHT_WIDTH-1:0] mem_weight;
    logic                    out_valid, out_ready;
    logic [ID_WIDTH-1:0]     out_pkt_id, out_dst_id;
    logic [WEIGHT_WIDTH-1:0] out_weight;

    modport slave (
        input  pkt_valid, pkt_id, cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask,
               mem_dst_id, mem_weight, out_ready,
        output pkt_ready, cfg_ready, mem_cs, mem_wr, mem_flush, mem_cmp, mem_addr, mem_data,
               mem_mask, mem_pkt_id, out_valid, out_pkt_id, out_dst_id, out_weight
    );
    modport master (
        output pkt_valid, pkt_id, cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask,
               mem_dst_id, mem_weight, out_ready,
        input  pkt_ready, cfg_ready, mem_cs, mem_wr, mem_flush, mem_cmp, mem_addr, mem_data,
               mem_mask, mem_pkt_id, out_valid, out_pkt_id, out_dst_id, out_weight
    );
endinterface

// File: rtl/tcam_lookup_sched.sv
// tcam_lookup_sched: queues packet IDs and schedules TCAM lookups/config ops around its COMPARE/READ phase.
// Define MISS_DROP_EN to drop misses (dst 0) and count them on miss_cnt instead of returning them.
module tcam_lookup_sched #(
    parameter int ID_WIDTH     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ADDR_SIZE    = 4,
    parameter int BITS         = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input logic clk,
    input logic rst_n,
    tcam_lookup_sched_if.slave bus
`ifdef MISS_DROP_EN
    ,
    output logic [15:0] miss_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CFG, LOOKUP, RESP} state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_CMP, PH_READ} phase_t;

    state_t              state, state_nx, dispatch;
    phase_t              ph;
    logic [ID_WIDTH-1:0] q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PW:0]         count;
    logic                full, push, capture, pending, drop;

    assign full          = count == (PW+1)'(FIFO_DEPTH);
    assign push          = bus.pkt_valid && !full;
    assign capture       = state == LOOKUP && ph == PH_READ;
    // an ID being pushed this cycle counts as queued so an idle lookup can start immediately
    assign pending       = count != '0 || push;
    assign bus.pkt_ready = !full;
    assign bus.mem_cmp   = ph == PH_CMP;
`ifdef MISS_DROP_EN
    assign drop = bus.mem_dst_id == '0;
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk)
        if (push) q[wr_ptr] <= bus.pkt_id;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(capture);
            count  <= count + (PW+1)'(push) - (PW+1)'(capture);
        end

    // shadow of the TCAM's free-running phase; any write/flush knocks it back to IDLE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ph         <= PH_IDLE;
            bus.mem_cs <= 1'b0;
        end else begin
            ph         <= ph == PH_CMP ? PH_READ : (!bus.mem_wr && !bus.mem_flush) ? PH_CMP : PH_IDLE;
            bus.mem_cs <= 1'b1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // new work only launches outside COMPARE so the lookup's COMPARE follows on the next cycle
    assign dispatch = ph == PH_CMP ? IDLE : bus.cfg_valid ? CFG : pending ? LOOKUP : IDLE;

    always_comb begin
        state_nx = state == IDLE   ? dispatch :
                   state == CFG    ? IDLE :
                   state == LOOKUP ? (capture ? (drop ? IDLE : RESP) : LOOKUP) :
                   bus.out_ready   ? dispatch : RESP;
    end

    always_comb begin
        bus.cfg_ready  = state == CFG;
        bus.mem_wr     = state == CFG && !bus.cfg_flush;
        bus.mem_flush  = state == CFG && bus.cfg_flush;
        bus.mem_addr   = state == CFG ? bus.cfg_addr : '0;
        bus.mem_data   = state == CFG ? bus.cfg_data : '0;
        bus.mem_mask   = state == CFG ? bus.cfg_mask : '0;
        bus.mem_pkt_id = state == LOOKUP ? q[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_pkt_id <= '0;
            bus.out_dst_id <= '0;
            bus.out_weight <= '0;
        end else if (capture && !drop) begin
            bus.out_valid  <= 1'b1;
            bus.out_pkt_id <= q[rd_ptr];
            bus.out_dst_id <= bus.mem_dst_id;
            bus.out_weight <= bus.mem_weight;
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end

`ifdef MISS_DROP_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) miss_cnt <= '0;
        else if (capture && drop && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
`endif
endmodule
